// File: rtl/mm_reg_master_pkg.sv
// Shared types and constants for the MM register initiator.
package mm_reg_master_pkg;

    localparam int MM_ADDR_W = 10;
    localparam int MM_DATA_W = 64;

    // Value returned to the host when a read receives no data in time.
    localparam logic [MM_DATA_W-1:0] DEFAULT_TIMEOUT_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } mmState_e;

    typedef struct packed {
        logic                 write;
        logic [MM_ADDR_W-1:0] addr;
        logic [MM_DATA_W-1:0] wdata;
    } mmReq_t;

endpackage

// File: rtl/mm_reg_master.sv
// Single-outstanding register bus initiator: one request in, one strobe out,
// bounded wait for read data, one-cycle response back to the host.
module mm_reg_master
    import mm_reg_master_pkg::*;
#(
    parameter logic [15:0]          pTIMEOUT      = 16'd64,
    parameter logic [MM_DATA_W-1:0] pTIMEOUT_DATA = DEFAULT_TIMEOUT_DATA
) (
    input  logic                 iCLK_100M,
    input  logic                 iRST_100M_n,
    input  logic                 iREQ_VALID,
    output logic                 oREQ_READY,
    input  logic                 iREQ_WRITE,
    input  logic [MM_ADDR_W-1:0] iREQ_ADDR,
    input  logic [MM_DATA_W-1:0] iREQ_WDATA,
    output logic                 oRSP_VALID,
    output logic [MM_DATA_W-1:0] oRSP_RDATA,
    output logic                 oRSP_TIMEOUT,
    output logic [MM_ADDR_W-1:0] oMM_ADDRESS,
    output logic [MM_DATA_W-1:0] oMM_WR_DATA,
    output logic                 oMM_WR_EN,
    output logic                 oMM_RD_EN,
    input  logic [MM_DATA_W-1:0] iMM_RD_DATA,
    input  logic                 iMM_RD_DATA_V,
    output logic [15:0]          oTIMEOUT_CNT
);

    mmState_e             stateReg, stateNext;
    mmReq_t               reqReg, reqNext;
    logic [15:0]          timerReg, timerNext;
    logic                 readyReg, readyNext;
    logic                 wrEnReg, wrEnNext;
    logic                 rdEnReg, rdEnNext;
    logic                 rspValidReg, rspValidNext;
    logic [MM_DATA_W-1:0] rspRdataReg, rspRdataNext;
    logic                 rspTimeoutReg, rspTimeoutNext;
    logic [15:0]          timeoutCntReg, timeoutCntNext;

    // State, holding registers and every output are flops; ready comes out of reset high.
    always_ff @(posedge iCLK_100M) begin
        if (!iRST_100M_n) begin
            stateReg      <= IDLE;
            reqReg        <= '0;
            timerReg      <= '0;
            readyReg      <= 1'b1;
            wrEnReg       <= 1'b0;
            rdEnReg       <= 1'b0;
            rspValidReg   <= 1'b0;
            rspRdataReg   <= '0;
            rspTimeoutReg <= 1'b0;
            timeoutCntReg <= '0;
        end else begin
            stateReg      <= stateNext;
            reqReg        <= reqNext;
            timerReg      <= timerNext;
            readyReg      <= readyNext;
            wrEnReg       <= wrEnNext;
            rdEnReg       <= rdEnNext;
            rspValidReg   <= rspValidNext;
            rspRdataReg   <= rspRdataNext;
            rspTimeoutReg <= rspTimeoutNext;
            timeoutCntReg <= timeoutCntNext;
        end
    end

    // Next state plus next output values; outputs are computed one cycle
    // ahead so they appear registered in the state they belong to.
    always_comb begin
        stateNext      = stateReg;
        reqNext        = reqReg;
        timerNext      = timerReg;
        wrEnNext       = 1'b0;
        rdEnNext       = 1'b0;
        rspValidNext   = 1'b0;
        rspRdataNext   = '0;
        rspTimeoutNext = 1'b0;
        timeoutCntNext = timeoutCntReg;

        case (stateReg)
            IDLE: begin
                if (iREQ_VALID && readyReg) begin
                    reqNext.write = iREQ_WRITE;
                    reqNext.addr  = iREQ_ADDR;
                    reqNext.wdata = iREQ_WDATA;
                    wrEnNext      = iREQ_WRITE;
                    rdEnNext      = !iREQ_WRITE;
                    stateNext     = ISSUE;
                end
            end
            ISSUE: begin
                if (reqReg.write) begin
                    // Writes complete immediately with a zero, non-timeout response.
                    rspValidNext = 1'b1;
                    stateNext    = RESP;
                end else begin
                    timerNext = pTIMEOUT;
                    stateNext = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (iMM_RD_DATA_V) begin
                    // Data takes priority over an expiring timer.
                    rspValidNext = 1'b1;
                    rspRdataNext = iMM_RD_DATA;
                    stateNext    = RESP;
                end else if (timerReg == 16'd1) begin
                    rspValidNext   = 1'b1;
                    rspTimeoutNext = 1'b1;
                    rspRdataNext   = pTIMEOUT_DATA;
                    stateNext      = RESP;
                    if (timeoutCntReg != 16'hFFFF) begin
                        timeoutCntNext = timeoutCntReg + 16'd1;
                    end
                end else begin
                    timerNext = timerReg - 16'd1;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign readyNext = (stateNext == IDLE);

    assign oREQ_READY   = readyReg;
    assign oRSP_VALID   = rspValidReg;
    assign oRSP_RDATA   = rspRdataReg;
    assign oRSP_TIMEOUT = rspTimeoutReg;
    assign oMM_ADDRESS  = reqReg.addr;
    assign oMM_WR_DATA  = reqReg.wdata;
    assign oMM_WR_EN    = wrEnReg;
    assign oMM_RD_EN    = rdEnReg;
    assign oTIMEOUT_CNT = timeoutCntReg;

endmodule

// File: tb/tb_mm_reg_master.sv
// Self-checking bench for mm_reg_master: a cycle timeline of expected outputs
// is derived from the latency rules per transaction and compared every cycle.
module tb_mm_reg_master;

    localparam logic [15:0] TO    = 16'd4;
    localparam logic [63:0] TDATA = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam int          MAXC  = 8192;

    logic        clk = 1'b0;
    logic        rstn;
    logic        reqValid, reqReady, reqWrite;
    logic [9:0]  reqAddr;
    logic [63:0] reqWdata;
    logic        rspValid, rspTimeout;
    logic [63:0] rspRdata;
    logic [9:0]  mmAddr;
    logic [63:0] mmWrData;
    logic        mmWrEn, mmRdEn;
    logic [63:0] mmRdData;
    logic        mmRdDataV;
    logic [15:0] toCnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected timeline, indexed by cycle number.
    bit        expReady [MAXC];
    bit        expWrEn  [MAXC];
    bit        expRdEn  [MAXC];
    bit        expRspV  [MAXC];
    bit        expTo    [MAXC];
    bit        skipReady[MAXC];
    bit        incCnt   [MAXC];
    bit        clrCnt   [MAXC];
    bit [63:0] expRdata [MAXC];
    bit [63:0] expWd    [MAXC];
    bit [9:0]  expAddr  [MAXC];
    logic [15:0] modelCnt = 16'd0;

    // Observed values for literal spot checks.
    logic        obsReady[MAXC];
    logic        obsWrEn [MAXC];
    logic        obsRdEn [MAXC];
    logic        obsRspV [MAXC];
    logic        obsTo   [MAXC];
    logic [63:0] obsRdata[MAXC];
    logic [63:0] obsWd   [MAXC];
    logic [9:0]  obsAddr [MAXC];
    logic [15:0] obsCnt  [MAXC];

    mm_reg_master #(
        .pTIMEOUT      (TO),
        .pTIMEOUT_DATA (TDATA)
    ) dut (
        .iCLK_100M     (clk),
        .iRST_100M_n   (rstn),
        .iREQ_VALID    (reqValid),
        .oREQ_READY    (reqReady),
        .iREQ_WRITE    (reqWrite),
        .iREQ_ADDR     (reqAddr),
        .iREQ_WDATA    (reqWdata),
        .oRSP_VALID    (rspValid),
        .oRSP_RDATA    (rspRdata),
        .oRSP_TIMEOUT  (rspTimeout),
        .oMM_ADDRESS   (mmAddr),
        .oMM_WR_DATA   (mmWrData),
        .oMM_WR_EN     (mmWrEn),
        .oMM_RD_EN     (mmRdEn),
        .iMM_RD_DATA   (mmRdData),
        .iMM_RD_DATA_V (mmRdDataV),
        .oTIMEOUT_CNT  (toCnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] nextCnt(input logic [15:0] c, input bit clr, input bit inc);
        logic [15:0] n;
        n = clr ? 16'd0 : c;
        if (inc && n != 16'hFFFF) n = n + 16'd1;
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Cycle counter, saturating timeout-count model, and a bound on run length.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc + 1 < MAXC) modelCnt <= nextCnt(modelCnt, clrCnt[cyc+1], incCnt[cyc+1]);
        if (cyc >= MAXC - 4) begin
            $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
            $fatal(1, "cycle budget exhausted");
        end
    end

    // Compare every DUT output against the expected timeline mid-cycle.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            obsReady[cyc] <= reqReady;
            obsWrEn[cyc]  <= mmWrEn;
            obsRdEn[cyc]  <= mmRdEn;
            obsRspV[cyc]  <= rspValid;
            obsTo[cyc]    <= rspTimeout;
            obsRdata[cyc] <= rspRdata;
            obsWd[cyc]    <= mmWrData;
            obsAddr[cyc]  <= mmAddr;
            obsCnt[cyc]   <= toCnt;
            if (!skipReady[cyc]) check("ready", reqReady, expReady[cyc]);
            check("wr_en", mmWrEn, expWrEn[cyc]);
            check("rd_en", mmRdEn, expRdEn[cyc]);
            check("rsp_valid", rspValid, expRspV[cyc]);
            check("rsp_timeout", rspTimeout, expTo[cyc]);
            check("rsp_rdata", rspRdata, expRdata[cyc]);
            check("timeout_cnt", toCnt, modelCnt);
            if (expWrEn[cyc]) begin
                check("wr_addr", mmAddr, expAddr[cyc]);
                check("wr_data", mmWrData, expWd[cyc]);
            end
            if (expRdEn[cyc]) check("rd_addr", mmAddr, expAddr[cyc]);
        end
    end

    // One transaction starting in the current cycle; returns in the cycle
    // the initiator is ready again. lat outside 1..TO means the slave is silent.
    task automatic doReq(input bit wr, input logic [9:0] a, input logic [63:0] wd,
                         input logic [63:0] rd, input int lat, input bit hold,
                         input bit forceStray);
        int t0, r;
        bit served, tmo;
        t0     = cyc;
        served = !wr && lat >= 1 && lat <= int'(TO);
        tmo    = !wr && !served;
        r      = wr ? t0 + 2 : (served ? t0 + 2 + lat : t0 + 2 + int'(TO));

        reqValid  = 1'b1;
        reqWrite  = wr;
        reqAddr   = a;
        reqWdata  = wd;
        mmRdData  = {$urandom, $urandom};
        mmRdDataV = forceStray ? 1'b1 : 1'($urandom_range(0, 1));

        if (wr) begin
            expWrEn[t0+1] = 1'b1;
            expWd[t0+1]   = wd;
        end else begin
            expRdEn[t0+1] = 1'b1;
        end
        expAddr[t0+1] = a;
        for (int k = t0 + 1; k <= r; k++) expReady[k] = 1'b0;
        expRspV[r]  = 1'b1;
        expTo[r]    = tmo;
        expRdata[r] = wr ? 64'd0 : (served ? rd : TDATA);
        incCnt[r]   = tmo;

        for (int k = t0 + 1; k <= r; k++) begin
            @(posedge clk); #1;
            if (hold) begin
                reqValid = 1'b1;
                reqWrite = 1'($urandom);
                reqAddr  = 10'($urandom);
                reqWdata = {$urandom, $urandom};
            end else begin
                reqValid = 1'b0;
            end
            mmRdData = {$urandom, $urandom};
            if (served && k == r - 1) begin
                mmRdDataV = 1'b1;
                mmRdData  = rd;
            end else if (k > t0 + 1 && k < r) begin
                mmRdDataV = 1'b0;
            end else begin
                mmRdDataV = forceStray ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        $display("TXN t0=%0d %s addr=%0d lat=%0d rsp_at=%0d timeout=%0d", t0,
                 wr ? "WR" : "RD", a, lat, r, tmo);
    endtask

    task automatic idle(input int n, input bit forceStray);
        for (int i = 0; i < n; i++) begin
            reqValid  = 1'b0;
            mmRdData  = {$urandom, $urandom};
            mmRdDataV = forceStray ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int t0;
        bit rw, rh;
        int rl;

        for (int i = 0; i < MAXC; i++) expReady[i] = 1'b1;
        for (int i = 0; i < 4; i++) skipReady[i] = 1'b1;
        rstn = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0;
        mmRdData = '0; mmRdDataV = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed write.
        t0 = cyc;
        doReq(1'b1, 10'd17, 64'h5F5E100, 64'd0, 0, 1'b0, 1'b0);
        check("pin_w_wren", obsWrEn[t0+1], 1'b1);
        check("pin_w_addr", obsAddr[t0+1], 10'd17);
        check("pin_w_data", obsWd[t0+1], 64'h5F5E100);
        check("pin_w_rsp", obsRspV[t0+2], 1'b1);
        check("pin_w_rdata", obsRdata[t0+2], 64'd0);
        idle(1, 1'b0);

        // Directed read, data one cycle after the strobe.
        t0 = cyc;
        doReq(1'b0, 10'd3, 64'd0, 64'h0123_4567_89AB_CDEF, 1, 1'b0, 1'b0);
        check("pin_r_rden", obsRdEn[t0+1], 1'b1);
        check("pin_r_rsp", obsRspV[t0+3], 1'b1);
        check("pin_r_rdata", obsRdata[t0+3], 64'h0123_4567_89AB_CDEF);
        check("pin_r_to", obsTo[t0+3], 1'b0);
        idle(1, 1'b0);

        // Silent slave: timeout response.
        t0 = cyc;
        doReq(1'b0, 10'd9, 64'd0, 64'd0, 0, 1'b0, 1'b0);
        check("pin_to_rsp", obsRspV[t0+6], 1'b1);
        check("pin_to_rdata", obsRdata[t0+6], 64'hDEAD_BEEF_DEAD_BEEF);
        check("pin_to_flag", obsTo[t0+6], 1'b1);
        check("pin_to_cnt", obsCnt[t0+6], 16'd1);

        // Data on the last waiting cycle wins over the timer.
        t0 = cyc;
        doReq(1'b0, 10'd4, 64'd0, 64'hCAFE_F00D_1234_5678, 4, 1'b0, 1'b0);
        check("pin_last_rsp", obsRspV[t0+6], 1'b1);
        check("pin_last_to", obsTo[t0+6], 1'b0);
        check("pin_last_rdata", obsRdata[t0+6], 64'hCAFE_F00D_1234_5678);
        check("pin_last_cnt", obsCnt[t0+6], 16'd1);

        // Stray read-data strobes in IDLE and in a write's ISSUE cycle.
        idle(2, 1'b1);
        t0 = cyc;
        doReq(1'b1, 10'd900, 64'h1, 64'd0, 0, 1'b0, 1'b1);
        check("pin_stray_rsp", obsRspV[t0+2], 1'b1);
        check("pin_stray_rdata", obsRdata[t0+2], 64'd0);
        idle(1, 1'b0);

        // Reset while waiting for read data.
        t0 = cyc;
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 10'd5; mmRdDataV = 1'b0;
        expRdEn[t0+1] = 1'b1;
        expAddr[t0+1] = 10'd5;
        for (int k = t0 + 1; k <= t0 + 3; k++) expReady[k] = 1'b0;
        skipReady[t0+4] = 1'b1;
        skipReady[t0+5] = 1'b1;
        clrCnt[t0+4]    = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pin_rst_ready", obsReady[t0+6], 1'b1);
        check("pin_rst_norsp", obsRspV[t0+6], 1'b0);
        check("pin_rst_cnt", obsCnt[t0+5], 16'd0);
        $display("TXN t0=%0d RD addr=5 dropped by reset", t0);

        // Back-to-back writes with valid held high.
        t0 = cyc;
        doReq(1'b1, 10'd100, 64'hA, 64'd0, 0, 1'b1, 1'b0);
        doReq(1'b1, 10'd101, 64'hB, 64'd0, 0, 1'b1, 1'b0);
        doReq(1'b1, 10'd102, 64'hC, 64'd0, 0, 1'b1, 1'b0);
        idle(1, 1'b0);
        check("pin_b2b_1", obsWrEn[t0+4], 1'b1);
        check("pin_b2b_gap", obsWrEn[t0+3], 1'b0);
        check("pin_b2b_2", obsAddr[t0+7], 10'd102);

        // Randomized mix of reads, writes, latencies and spacing.
        for (int n = 0; n < 150; n++) begin
            rw = 1'($urandom_range(0, 1));
            rl = int'($urandom_range(0, int'(TO) + 1));
            rh = ($urandom_range(0, 3) == 0);
            doReq(rw, 10'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, rl, rh, 1'b0);
            if (!rh) idle(int'($urandom_range(0, 2)), 1'b0);
        end
        idle(3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
